// File: rtl/bcd_counter_nd.sv
// Multi-digit BCD up/down counter with prescaler, parallel load and wrap pulse.
// Every count nibble stays in 0..9 so downstream 7-segment decoders stay in range.
module bcd_counter_nd #(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  en,
   input  logic                  up,
   output logic [4*DIGITS-1:0]   count,
   output logic                  step,
   output logic                  wrap,
   output logic                  load_err
);

   localparam int W  = 4 * DIGITS;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre;
   logic [W-1:0]  cnt_up;
   logic [W-1:0]  cnt_dn;
   logic [W-1:0]  load_fix;
   logic          all9;
   logic          all0;
   logic          bad;

   // Ripple carry/borrow through all digits; carry out of the top means wrap.
   always_comb begin
      logic       c;
      logic       b;
      logic [3:0] d;
      logic [3:0] l;
      cnt_up   = '0;
      cnt_dn   = '0;
      load_fix = '0;
      bad      = 1'b0;
      c        = 1'b1;
      b        = 1'b1;
      d        = '0;
      l        = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = count[4*i +: 4];
         l = load_val[4*i +: 4];
         if (c) begin
            if (d == 4'd9) begin
               cnt_up[4*i +: 4] = 4'd0;
            end else begin
               cnt_up[4*i +: 4] = d + 4'd1;
               c = 1'b0;
            end
         end else begin
            cnt_up[4*i +: 4] = d;
         end
         if (b) begin
            if (d == 4'd0) begin
               cnt_dn[4*i +: 4] = 4'd9;
            end else begin
               cnt_dn[4*i +: 4] = d - 4'd1;
               b = 1'b0;
            end
         end else begin
            cnt_dn[4*i +: 4] = d;
         end
         if (l > 4'd9) begin
            load_fix[4*i +: 4] = 4'd0;
            bad = 1'b1;
         end else begin
            load_fix[4*i +: 4] = l;
         end
      end
      all9 = c;
      all0 = b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= '0;
         pre      <= '0;
         step     <= 1'b0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else if (clr) begin
         count    <= '0;
         pre      <= '0;
         step     <= 1'b0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else if (load) begin
         count    <= load_fix;
         pre      <= '0;
         step     <= 1'b0;
         wrap     <= 1'b0;
         load_err <= bad;
      end else begin
         step     <= 1'b0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
         if (en) begin
            if (pre == PMAX) begin
               pre  <= '0;
               step <= 1'b1;
               if (up) begin
                  count <= cnt_up;
                  wrap  <= all9;
               end else begin
                  count <= cnt_dn;
                  wrap  <= all0;
               end
            end else begin
               pre <= pre + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_counter_nd.sv
// Scoreboard bench: two counters (TICK_DIV 1 and 3) share stimulus and are
// compared against a decimal-arithmetic reference model.
module tb_bcd_counter_nd;

   typedef struct packed {
      logic [15:0] count;
      logic        step;
      logic        wrap;
      logic        lerr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        load = 1'b0;
   logic [15:0] load_val = '0;
   logic        en = 1'b0;
   logic        up = 1'b0;

   logic [15:0] count1, count3;
   logic        step1, step3, wrap1, wrap3, lerr1, lerr3;

   int checks = 0;
   int errors = 0;

   exp_t q1[$];
   exp_t q3[$];

   int mval[2];
   int mpre[2];
   int tdiv[2] = '{1, 3};

   always #5 clk = ~clk;

   bcd_counter_nd #(.DIGITS(4), .TICK_DIV(1)) d1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
      .load_val(load_val), .en(en), .up(up),
      .count(count1), .step(step1), .wrap(wrap1), .load_err(lerr1)
   );

   bcd_counter_nd #(.DIGITS(4), .TICK_DIV(3)) d3 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load(load),
      .load_val(load_val), .en(en), .up(up),
      .count(count3), .step(step3), .wrap(wrap3), .load_err(lerr3)
   );

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          t;
      r = '0;
      t = v;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: count held as a plain decimal integer 0..9999.
   task automatic model(input int k, output exp_t e);
      int nv;
      logic [3:0] nib;
      e = '0;
      if (clr) begin
         mval[k] = 0;
         mpre[k] = 0;
      end else if (load) begin
         nv = 0;
         for (int i = 3; i >= 0; i--) begin
            nib = load_val[4*i +: 4];
            if (nib > 4'd9) begin
               e.lerr = 1'b1;
               nib = 4'd0;
            end
            nv = nv * 10 + int'(nib);
         end
         mval[k] = nv;
         mpre[k] = 0;
      end else if (en) begin
         if (mpre[k] == tdiv[k] - 1) begin
            mpre[k] = 0;
            e.step = 1'b1;
            if (up) begin
               e.wrap = (mval[k] == 9999);
               mval[k] = (mval[k] + 1) % 10000;
            end else begin
               e.wrap = (mval[k] == 0);
               mval[k] = (mval[k] + 9999) % 10000;
            end
         end else begin
            mpre[k] = mpre[k] + 1;
         end
      end
      e.count = to_bcd(mval[k]);
   endtask

   task automatic cyc(input logic c, input logic l, input logic [15:0] lv,
                      input logic e_, input logic u);
      exp_t e;
      @(negedge clk);
      clr = c;
      load = l;
      load_val = lv;
      en = e_;
      up = u;
      model(0, e);
      q1.push_back(e);
      model(1, e);
      q3.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q1.size() > 0) begin
            e = q1.pop_front();
            check("d1.count", count1, e.count);
            check("d1.step", 16'(step1), 16'(e.step));
            check("d1.wrap", 16'(wrap1), 16'(e.wrap));
            check("d1.load_err", 16'(lerr1), 16'(e.lerr));
         end
         if (q3.size() > 0) begin
            e = q3.pop_front();
            check("d3.count", count3, e.count);
            check("d3.step", 16'(step3), 16'(e.step));
            check("d3.wrap", 16'(wrap3), 16'(e.wrap));
            check("d3.load_err", 16'(lerr3), 16'(e.lerr));
         end
      end
   end

   initial begin : stim
      mval = '{0, 0};
      mpre = '{0, 0};
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset.count1", count1, 16'h0000);
      check("reset.count3", count3, 16'h0000);
      check("reset.flags", {13'd0, step1, wrap1, lerr1}, 16'h0);

      repeat (12) cyc(0, 0, 0, 1, 1);
      cyc(0, 1, 16'h9998, 0, 1);
      repeat (6) cyc(0, 0, 0, 1, 1);
      cyc(0, 1, 16'h0001, 0, 0);
      repeat (6) cyc(0, 0, 0, 1, 0);
      cyc(0, 1, 16'h0100, 0, 0);
      repeat (3) cyc(0, 0, 0, 1, 0);

      // prescaler hold: stall mid-interval then resume
      cyc(1, 0, 0, 0, 1);
      repeat (4) cyc(0, 0, 0, 1, 1);
      repeat (5) cyc(0, 0, 0, 0, 1);
      repeat (6) cyc(0, 0, 0, 1, 1);

      cyc(0, 1, 16'h3A7F, 1, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(1, 1, 16'h5555, 1, 1);
      cyc(0, 0, 0, 0, 1);

      // asynchronous reset between edges at 0x1234
      cyc(0, 1, 16'h1234, 0, 1);
      cyc(0, 0, 0, 0, 1);
      @(negedge clk);
      clr = 0; load = 0; en = 0; up = 1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async.count1", count1, 16'h0000);
      check("async.count3", count3, 16'h0000);
      check("async.flags", {10'd0, step1, wrap1, lerr1, step3, wrap3, lerr3},
            16'h0);
      mval = '{0, 0};
      mpre = '{0, 0};
      @(negedge clk);
      rst_n = 1'b1;
      repeat (7) cyc(0, 0, 0, 1, 1);

      for (int n = 0; n < 600; n++) begin
         cyc(($urandom % 40) == 0, ($urandom % 15) == 0,
             16'($urandom), ($urandom % 4) != 0, ($urandom % 3) != 0);
      end
      for (int n = 0; n < 200; n++) begin
         cyc(0, ($urandom % 30) == 0,
             ($urandom % 2) ? 16'h9997 : 16'h0002, 1, ($urandom % 8) != 0);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (q1.size() != 0 || q3.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0",
                  q1.size(), q3.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
